// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall-bus, stage-index and controller-state definitions for pipeline_ctrl.
// Build option: PIPE_CTRL_PERF_EN adds stall/flush performance counters to the top.
package pipeline_ctrl_pkg;

   localparam int STALL_BUS_WIDTH = 5;
   typedef logic [STALL_BUS_WIDTH-1:0] STALL_BUS;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;

   typedef enum logic [1:0] {
      PCTRL_IDLE  = 2'd0,
      PCTRL_FLUSH = 2'd1,
      PCTRL_HOLD  = 2'd2
   } pctrl_state_t;

   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

   // Low 'depth' bits set: every stage up to and including the requester freezes.
   function automatic STALL_BUS thermometer(input int unsigned depth);
      STALL_BUS t;
      t = '0;
      for (int i = 0; i < STALL_BUS_WIDTH; i++) begin
         t[i] = (i < depth);
      end
      return t;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_encoder.sv
// Priority-to-thermometer mapping of per-stage stall requests; the deepest requester wins.
module stall_encoder
   import pipeline_ctrl_pkg::*;
(
   input  logic                       req_if,
   input  logic                       req_id,
   input  logic                       req_ex,
   input  logic                       req_mem,
   output logic [STALL_BUS_WIDTH-1:0] stall
);

   always_comb begin
      stall = '0;
      if (req_mem)     stall = thermometer(STALL_MEM + 1);
      else if (req_ex) stall = thermometer(STALL_EX + 1);
      else if (req_id) stall = thermometer(STALL_ID + 1);
      else if (req_if) stall = thermometer(STALL_IF + 1);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/exception controller: merges stall requests and sequences exception flush + PC redirect.
// Build option: PIPE_CTRL_PERF_EN adds stall_cycles and flush_count outputs.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall_req_if,
   input  logic                       stall_req_id,
   input  logic                       stall_req_ex,
   input  logic                       stall_req_mem,
   input  logic                       exc_valid,
   input  logic                       eret_flag,
   input  logic [ADDR_W-1:0]          cp0_epc,
   input  logic                       fetch_busy,
   output logic [STALL_BUS_WIDTH-1:0] stall,
   output logic                       flush,
   output logic                       redirect_valid,
   output logic [ADDR_W-1:0]          redirect_pc,
   output logic                       busy,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]                stall_cycles,
   output logic [15:0]                flush_count,
`endif
   output logic [1:0]                 state_dbg
);

   // Handshake: redirect_valid is held until the cycle fetch_busy is low;
   // that cycle is the acceptance, and the controller returns to IDLE after it.

   pctrl_state_t                 state;
   logic [STALL_BUS_WIDTH-1:0]   req_stall;
   logic                         exc_event;

   stall_encoder u_stall_encoder (
      .req_if  (stall_req_if),
      .req_id  (stall_req_id),
      .req_ex  (stall_req_ex),
      .req_mem (stall_req_mem),
      .stall   (req_stall)
   );

   assign exc_event = exc_valid | eret_flag;
   assign busy      = (state != PCTRL_IDLE);
   assign state_dbg = state;

   always_comb begin
      stall = req_stall;
      case (state)
         PCTRL_FLUSH: stall = '0;
         // The PC must be free to load the redirect target while held.
         PCTRL_HOLD:  stall[STALL_PC] = 1'b0;
         default:     stall = req_stall;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= PCTRL_IDLE;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         case (state)
            PCTRL_IDLE: begin
               if (exc_event) begin
                  state          <= PCTRL_FLUSH;
                  flush          <= 1'b1;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= eret_flag ? cp0_epc : EXC_VECTOR;
               end
            end
            PCTRL_FLUSH: begin
               flush          <= 1'b0;
               redirect_valid <= fetch_busy;
               state          <= fetch_busy ? PCTRL_HOLD : PCTRL_IDLE;
            end
            PCTRL_HOLD: begin
               if (!fetch_busy) begin
                  state          <= PCTRL_IDLE;
                  redirect_valid <= 1'b0;
               end
            end
            default: begin
               state          <= PCTRL_IDLE;
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if ((stall != '0) && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
         if ((state == PCTRL_IDLE) && exc_event) flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random traffic against a behavioural model.
module tb_pipeline_ctrl;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_req_if = 1'b0, stall_req_id = 1'b0, stall_req_ex = 1'b0, stall_req_mem = 1'b0;
   logic        exc_valid = 1'b0, eret_flag = 1'b0, fetch_busy = 1'b0;
   logic [31:0] cp0_epc = '0;
   logic [4:0]  stall;
   logic        flush, redirect_valid, busy;
   logic [31:0] redirect_pc;
   logic [1:0]  state_dbg;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: "flush pulse pending" and "redirect outstanding" flags.
   logic        m_flush, m_rv;
   logic [31:0] m_pc;
   longint      m_stall_cycles;
   int          m_flush_count;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall_req_if   (stall_req_if),
      .stall_req_id   (stall_req_id),
      .stall_req_ex   (stall_req_ex),
      .stall_req_mem  (stall_req_mem),
      .exc_valid      (exc_valid),
      .eret_flag      (eret_flag),
      .cp0_epc        (cp0_epc),
      .fetch_busy     (fetch_busy),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
`ifdef PIPE_CTRL_PERF_EN
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count),
`endif
      .state_dbg      (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_stall();
      int depth;
      logic [4:0] s;
      depth = stall_req_mem ? 5 : stall_req_ex ? 4 : stall_req_id ? 3 : stall_req_if ? 2 : 0;
      s = 5'((32'd1 << depth) - 32'd1);
      if (m_flush) s = 5'd0;
      else if (m_rv) s[0] = 1'b0;
      return s;
   endfunction

   task automatic reset_model();
      m_flush = 1'b0; m_rv = 1'b0; m_pc = '0;
      m_stall_cycles = 0; m_flush_count = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".stall"}, 32'(stall), 32'(exp_stall()));
      check({tag, ".flush"}, 32'(flush), 32'(m_flush));
      check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_rv));
      check({tag, ".redirect_pc"}, redirect_pc, m_pc);
      check({tag, ".busy"}, 32'(busy), 32'(m_flush | m_rv));
`ifdef PIPE_CTRL_PERF_EN
      check({tag, ".stall_cycles"}, stall_cycles, 32'(m_stall_cycles));
      check({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush_count & 16'hFFFF));
`endif
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
   task automatic cycle(input string tag, input logic [3:0] req, input logic exc, input logic eret,
                        input logic [31:0] epc, input logic fb);
      {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if} = req;
      exc_valid = exc; eret_flag = eret; cp0_epc = epc; fetch_busy = fb;
      #1;
      check_all(tag);
      @(posedge clk);
      if (exp_stall() != 5'd0 && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
      if (m_flush) begin
         m_flush = 1'b0;
         m_rv    = fb;
      end else if (m_rv) begin
         m_rv = fb;
      end else if (exc | eret) begin
         m_flush = 1'b1;
         m_rv    = 1'b1;
         m_pc    = eret ? epc : VEC;
         m_flush_count++;
      end
      #1;
   endtask

   initial begin
      reset_model();
      #2;
      check_all("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // Stall encoding
      cycle("ex_only", 4'b0100, 0, 0, 0, 0);
      cycle("ex_drop", 4'b0000, 0, 0, 0, 0);
      cycle("id_mem",  4'b1010, 0, 0, 0, 0);
      cycle("if_only", 4'b0001, 0, 0, 0, 0);

      // Exception with fetch ready
      cycle("exc_ev",  4'b0000, 1, 0, 0, 0);
      cycle("exc_fl",  4'b0000, 0, 0, 0, 0);
      cycle("exc_end", 4'b0000, 0, 0, 0, 0);

      // ERET + held fetch, second exception in HOLD, mem stall during FLUSH
      cycle("eret_ev", 4'b0100, 1, 1, 32'h80001234, 1);
      cycle("eret_fl", 4'b1000, 0, 0, 0, 1);
      cycle("hold1",   4'b0010, 1, 0, 0, 1);
      cycle("hold2",   4'b1000, 0, 1, 32'h1111_0000, 1);
      cycle("hold3",   4'b0000, 0, 0, 0, 0);
      cycle("eret_end",4'b0000, 0, 0, 0, 0);

      // Asynchronous reset while holding a redirect
      cycle("rhold_ev", 4'b0000, 1, 0, 0, 1);
      cycle("rhold_fl", 4'b0000, 0, 0, 0, 1);
      cycle("rhold_h",  4'b0000, 0, 0, 0, 1);
      rst = 1'b0;
      reset_model();
      #1;
      check_all("async_rst");
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Four-cycle stall after reset
      repeat (4) cycle("stall4", 4'b0100, 0, 0, 0, 0);
      cycle("stall4_end", 4'b0000, 0, 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         logic [3:0] req;
         req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         cycle("rand", req, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
               $urandom, $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and exception controller that drives the `stall_current_stage`, `stall_next_stage` and `flush` inputs of every inter-stage pipeline register (PCIF, IFID, IDEX, EXMEM, MEMWB) and the PC redirect. It merges per-stage stall requests into a monotonic stall vector. It also turns MEM-stage exception/eret reports into a registered flush pulse plus a held redirect address. It sits beside the datapath in the core top and is the only source of stall/flush.

## Interface
- `EXC_VECTOR`, default 32'hBFC00380: general exception entry address.
- `ADDR_W`, default 32: PC width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `stall_req_if`  in  1: fetch not ready (instruction memory wait).
- `stall_req_id`  in  1: load-use hazard.
- `stall_req_ex`  in  1: multi-cycle MUL/DIV busy.
- `stall_req_mem`  in  1: data memory wait.
- `exc_valid`  in  1: MEM stage reports an exception (syscall, break, interrupt, overflow, address error).
- `eret_flag`  in  1: MEM stage holds ERET.
- `cp0_epc`  in  ADDR_W: current EPC from CP0.
- `fetch_busy`  in  1: IF cannot accept a redirect this cycle.
- `stall`  out  5: bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM. Register k/k+1 uses `stall[k]` as `stall_current_stage` and `stall[k+1]` as `stall_next_stage`. Reset 5'b0.
- `flush`  out  1: clears all pipeline registers. Reset 0.
- `redirect_valid`  out  1: PC must load `redirect_pc`. Reset 0.
- `redirect_pc`  out  ADDR_W: redirect target. Reset 0.
- `busy`  out  1: state ≠ IDLE. Reset 0.

## Operation
- Stall vector is combinational and monotonic:
  - mem req → 5'b11111
  - else ex → 5'b01111
  - else id → 5'b00111
  - else if → 5'b00011
  - else 0
- An exception event is `exc_valid | eret_flag`. Target = `eret_flag ? cp0_epc : EXC_VECTOR`. If both are set, eret wins.
- FSM has three states: IDLE, FLUSH, HOLD.
  - IDLE: on an event, capture the target into `redirect_pc` and go to FLUSH. Otherwise stay.
  - FLUSH: `flush`=1 and `redirect_valid`=1 for exactly one cycle; `stall` forced to 0. Next state is HOLD if `fetch_busy`, else IDLE.
  - HOLD: `redirect_valid`=1, `flush`=0, `stall[0]`=0. Other stall bits follow requests. Exit to IDLE on the first cycle with `fetch_busy`=0, with `redirect_valid` still asserted in that cycle.
- Outside IDLE, exception inputs are ignored; the flushed pipeline cannot produce a legitimate event.
- `flush` takes priority over every stall request.
- `redirect_pc` is stable from FLUSH until the cycle after the redirect is accepted.

## Timing
- Stall: zero latency, purely combinational from requests and state.
- Exception: `flush`/`redirect_valid` rise one cycle after the event is sampled (registered, so there is no combinational path from MEM to the PC mux).
- Redirect accepted at the latest in the first cycle with `fetch_busy`=0 after FLUSH.
- Asynchronous reset mid-FLUSH or mid-HOLD: state goes to IDLE and all outputs take their reset values immediately. Pending redirects are lost.
- An event coinciding with stall requests in IDLE is still captured; the requests do not delay the capture.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds output `stall_cycles` (32 b, reset 0): increments every cycle `stall`≠0, saturating at 32'hFFFFFFFF.
  - Adds output `flush_count` (16 b, reset 0): increments on each FLUSH entry, wrapping.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- Shared package/header `bus.v`:
  - `STALL_BUS_WIDTH` (5) and `STALL_BUS`.
  - Stage index constants `STALL_PC` … `STALL_MEM`.
  - FSM encodings `PCTRL_IDLE` = 2'd0, `PCTRL_FLUSH` = 2'd1, `PCTRL_HOLD` = 2'd2.
  - Default `EXC_VECTOR`.
- One sub-module, `stall_encoder`, holds the combinational priority-to-thermometer mapping. The FSM stays in `pipeline_ctrl`.

## Test plan
- `stall_req_ex`=1 alone → `stall`=5'b01111, `flush`=0. Drop it → `stall`=0 the same cycle.
- `stall_req_id`=1 and `stall_req_mem`=1 together → `stall`=5'b11111.
- `exc_valid` pulse at cycle N, `fetch_busy`=0 → at N+1: `flush`=1, `redirect_valid`=1, `redirect_pc`=32'hBFC00380. At N+2 all are 0 and `busy`=0.
- `eret_flag`=1 with `cp0_epc`=32'h80001234, `fetch_busy` held 3 cycles → FLUSH for 1 cycle, then HOLD with `redirect_pc`=32'h80001234 until `fetch_busy` falls, then IDLE. `flush` is high for exactly 1 cycle.
- A second `exc_valid` during HOLD → ignored; `redirect_pc` unchanged. `stall_req_mem` during FLUSH → `stall`=0.
- `rst` low while in HOLD → `redirect_valid`=0 and `busy`=0 without a clock edge. With `PIPE_CTRL_PERF_EN`, `stall_cycles`=0 after reset and counts exactly 4 over a 4-cycle stall.
